key_event: RTL and testbench
============================

KEY_EVENT -- requirements
Module: key_event

Parameters
REQ-001 The block SHALL have parameter W, default 3, giving the number of independent key channels.
REQ-002 The block SHALL have parameter TIME_LONG, default 50_000_000 cycles (1 s at 50 MHz), giving the long-press threshold; TIME_LONG SHALL be at least 2.
REQ-003 The block SHALL have parameter TIME_REPEAT, default 10_000_000 cycles (200 ms), giving the auto-repeat period; TIME_REPEAT SHALL be at least 2.

Interface
REQ-004 clk  input  1  Single system clock; all logic SHALL be clocked on the rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 key_in  input  W  Debounced, synchronous key levels; active-low (0 = pressed, 1 = released).
REQ-007 press_pulse  output  W  One-cycle pulse per channel when a press is accepted.
REQ-008 short_pulse  output  W  One-cycle pulse per channel when a key is released before the long threshold.
REQ-009 long_pulse  output  W  One-cycle pulse per channel when the long threshold is reached.
REQ-010 repeat_pulse  output  W  One-cycle pulse per channel every TIME_REPEAT cycles while a long press continues.
REQ-011 release_pulse  output  W  One-cycle pulse per channel on any accepted release.
REQ-012 held  output  W  Level, active-high, per channel while the channel FSM is not IDLE.

Function
REQ-013 Each channel SHALL be fully independent, with its own input register, FSM and counter; channels SHALL NOT share state.
REQ-014 Input stage: key_in SHALL be registered once into key_r; key_r[i] SHALL drive channel i.
REQ-015 Each channel FSM SHALL have exactly three states: IDLE, PRESS and LONG.
REQ-016 IDLE, key_r=0 → PRESS; press_pulse=1 in the following cycle; cnt=0.
REQ-017 PRESS, key_r=1 → IDLE; short_pulse=1 and release_pulse=1 in the same following cycle.
REQ-018 PRESS, key_r=0 and cnt==TIME_LONG-1 → LONG; long_pulse=1 in the following cycle; cnt=0.
REQ-019 PRESS, otherwise: cnt SHALL increment by 1 each cycle.
REQ-020 LONG, key_r=1 → IDLE; release_pulse=1 in the following cycle; short_pulse SHALL stay 0.
REQ-021 LONG, key_r=0 and cnt==TIME_REPEAT-1 → stay in LONG; repeat_pulse=1 in the following cycle; cnt=0.
REQ-022 LONG, otherwise: cnt SHALL increment by 1 each cycle.
REQ-023 Release SHALL take priority over a long or repeat event in the same cycle; the simultaneous long/repeat event SHALL be dropped.
REQ-024 In IDLE, cnt SHALL be held at 0.
REQ-025 cnt SHALL be 32 bits wide and SHALL never exceed max(TIME_LONG, TIME_REPEAT)-1 (no wrap-around).
REQ-026 All pulse outputs SHALL be registered, SHALL be high for exactly one cycle per event, and SHALL be 0 in every other cycle.
REQ-027 held SHALL be registered and SHALL equal (next state != IDLE), so it rises in the same cycle as press_pulse and falls in the same cycle as release_pulse.
REQ-028 Latency: a key_in change sampled at edge E SHALL produce its event output high in the cycle following edge E+1.
REQ-029 A press lasting exactly one sampled cycle SHALL produce press_pulse followed by short_pulse + release_pulse.
REQ-030 A key already held (key_in=0) when reset deasserts SHALL be accepted as a new press after the input register stage.

Reset
REQ-031 While rst_n=0: key_r SHALL be all 1; every FSM SHALL be in IDLE; every cnt SHALL be 0; all pulse outputs and held SHALL be 0.
REQ-032 Reset asserted mid-press SHALL abort the press immediately, with no release_pulse and no short_pulse, neither during nor after reset.

Verification (W=3, TIME_LONG=10, TIME_REPEAT=4)
REQ-033 Short press: key_in[0]=0 for 5 cycles → press_pulse[0] once, then short_pulse[0] and release_pulse[0] together; long_pulse=0; held[0] high for 5 cycles.
REQ-034 Long press with repeat: key_in[1]=0 for 25 cycles → press_pulse[1]; long_pulse[1] 10 cycles after press_pulse[1]; repeat_pulse[1] at +4, +8, +12 after long_pulse; release_pulse[1] only; short_pulse=0.
REQ-035 Boundary: release sampled in the cycle where cnt==TIME_LONG-1 → short_pulse and release_pulse; no long_pulse.
REQ-036 Concurrency: channel 0 short press overlapping channel 2 long press → each channel's pulse sequence is identical to its isolated run.
REQ-037 Reset mid-press: rst_n=0 during LONG → all outputs 0 immediately; after rst_n=1 with key_in=1 → no pulses.
REQ-038 Held through reset: key_in[2]=0 held while rst_n rises → press_pulse[2] 2 cycles after the first sampling edge.

Source files
------------

// File: rtl/key_event_if.sv
// Key event bus: debounced active-low key levels in, per-channel event pulses and held level out.
interface key_event_if #(
    parameter int W = 3
);
    logic [W-1:0] key_in;
    logic [W-1:0] press_pulse;
    logic [W-1:0] short_pulse;
    logic [W-1:0] long_pulse;
    logic [W-1:0] repeat_pulse;
    logic [W-1:0] release_pulse;
    logic [W-1:0] held;

    modport master (
        output key_in,
        input  press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held
    );

    modport slave (
        input  key_in,
        output press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held
    );
endinterface

// File: rtl/key_event.sv
// Per-channel key press classifier: press, short, long, auto-repeat and release events
// from debounced active-low key levels, one independent FSM and counter per channel.
module key_event #(
    parameter int          W           = 3,
    parameter int unsigned TIME_LONG   = 50_000_000,
    parameter int unsigned TIME_REPEAT = 10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    key_event_if.slave   bus
);

    localparam logic [31:0] LONG_LAST   = 32'(TIME_LONG - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(TIME_REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_e;

    state_e       state_q [W];
    logic [31:0]  cnt_q   [W];
    logic [W-1:0] key_r_q;
    logic [W-1:0] press_q;
    logic [W-1:0] short_q;
    logic [W-1:0] long_q;
    logic [W-1:0] repeat_q;
    logic [W-1:0] release_q;
    logic [W-1:0] held_q;

    // Release is checked before the threshold compare so it wins over a coincident long/repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r_q   <= '1;
            press_q   <= '0;
            short_q   <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            release_q <= '0;
            held_q    <= '0;
            for (int i = 0; i < W; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            key_r_q   <= bus.key_in;
            press_q   <= '0;
            short_q   <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            release_q <= '0;
            for (int i = 0; i < W; i++) begin
                case (state_q[i])
                    IDLE: begin
                        cnt_q[i] <= '0;
                        if (!key_r_q[i]) begin
                            state_q[i] <= PRESS;
                            press_q[i] <= 1'b1;
                            held_q[i]  <= 1'b1;
                        end else begin
                            held_q[i]  <= 1'b0;
                        end
                    end
                    PRESS: begin
                        if (key_r_q[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            short_q[i]   <= 1'b1;
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                        end else if (cnt_q[i] == LONG_LAST) begin
                            state_q[i] <= LONG;
                            cnt_q[i]   <= '0;
                            long_q[i]  <= 1'b1;
                            held_q[i]  <= 1'b1;
                        end else begin
                            cnt_q[i]   <= cnt_q[i] + 32'd1;
                            held_q[i]  <= 1'b1;
                        end
                    end
                    LONG: begin
                        if (key_r_q[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                        end else if (cnt_q[i] == REPEAT_LAST) begin
                            cnt_q[i]    <= '0;
                            repeat_q[i] <= 1'b1;
                            held_q[i]   <= 1'b1;
                        end else begin
                            cnt_q[i]    <= cnt_q[i] + 32'd1;
                            held_q[i]   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                        held_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.short_pulse   = short_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.release_pulse = release_q;
    assign bus.held          = held_q;

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: stimulus pushes timed expected events per channel,
// a negedge monitor pops and compares whenever a channel emits a pulse.
module tb_key_event;

    localparam int W  = 3;
    localparam int TL = 10;
    localparam int TR = 4;

    // Event vector layout: {press, short, long, repeat, release, held}
    localparam logic [5:0] EV_PRESS = 6'b100001;
    localparam logic [5:0] EV_SHORT = 6'b010010;
    localparam logic [5:0] EV_LONG  = 6'b001001;
    localparam logic [5:0] EV_REP   = 6'b000101;
    localparam logic [5:0] EV_REL   = 6'b000010;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int nEnt;
    int entCh    [4];
    int entStart [4];
    int entLen   [4];

    key_event_if #(.W(W)) bus ();

    key_event #(
        .W(W),
        .TIME_LONG(TL),
        .TIME_REPEAT(TR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushExp(input int ch, input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        case (ch)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qSize(input int ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t popExp(input int ch);
        case (ch)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Key low on negedge c for n negedges: sampled from edge c+1, press visible at c+2.
    function automatic void pushModel(input int ch, input int c, input int n);
        pushExp(ch, c + 2, EV_PRESS);
        if (n <= TL) begin
            pushExp(ch, c + n + 2, EV_SHORT);
        end else begin
            pushExp(ch, c + TL + 2, EV_LONG);
            for (int r = c + TL + 2 + TR; r < c + n + 2; r += TR)
                pushExp(ch, r, EV_REP);
            pushExp(ch, c + n + 2, EV_REL);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic setEnt(input int idx, input int ch, input int start, input int len);
        entCh[idx]    = ch;
        entStart[idx] = start;
        entLen[idx]   = len;
    endtask

    task automatic applyStimulus(input int total, input bit releaseReset);
        int base;
        logic [W-1:0] v;
        @(negedge clk);
        base = cyc;
        if (releaseReset) rst_n = 1'b1;
        for (int k = 0; k < nEnt; k++) pushModel(entCh[k], base + entStart[k], entLen[k]);
        for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge clk);
            v = '1;
            for (int k = 0; k < nEnt; k++)
                if (t >= entStart[k] && t < entStart[k] + entLen[k]) v[entCh[k]] = 1'b0;
            bus.key_in = v;
        end
        @(negedge clk);
        bus.key_in = '1;
        repeat (6) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_press"},   32'(bus.press_pulse),   32'd0);
        checkOutput({tag, "_short"},   32'(bus.short_pulse),   32'd0);
        checkOutput({tag, "_long"},    32'(bus.long_pulse),    32'd0);
        checkOutput({tag, "_repeat"},  32'(bus.repeat_pulse),  32'd0);
        checkOutput({tag, "_release"}, 32'(bus.release_pulse), 32'd0);
        checkOutput({tag, "_held"},    32'(bus.held),          32'd0);
    endtask

    always @(negedge clk) begin : monitor
        logic [5:0] v;
        exp_t e;
        if (rst_n) begin
            for (int ch = 0; ch < W; ch++) begin
                v = {bus.press_pulse[ch], bus.short_pulse[ch], bus.long_pulse[ch],
                     bus.repeat_pulse[ch], bus.release_pulse[ch], bus.held[ch]};
                if (v[5:1] != 5'b0) begin
                    if (qSize(ch) == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_ch%0d: got %b at cycle %0d expected no event",
                                 ch, v, cyc);
                    end else begin
                        e = popExp(ch);
                        checkOutput($sformatf("event_cycle_ch%0d", ch), cyc, e.cyc);
                        checkOutput($sformatf("event_vec_ch%0d@%0d", ch, e.cyc), 32'(v), 32'(e.vec));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin : stimulus
        int base;
        bus.key_in = '1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] short press ch0");
        nEnt = 1; setEnt(0, 0, 0, 5);
        applyStimulus(5, 1'b0);

        $display("[TB] long press with repeat ch1");
        nEnt = 1; setEnt(0, 1, 0, 25);
        applyStimulus(25, 1'b0);

        $display("[TB] release exactly at long threshold ch0, one past on ch1");
        nEnt = 2; setEnt(0, 0, 0, 10); setEnt(1, 1, 0, 11);
        applyStimulus(11, 1'b0);

        $display("[TB] single-cycle press ch2");
        nEnt = 1; setEnt(0, 2, 0, 1);
        applyStimulus(1, 1'b0);

        $display("[TB] release coincident with repeat ch1");
        nEnt = 1; setEnt(0, 1, 0, 14);
        applyStimulus(14, 1'b0);

        $display("[TB] overlapping channels");
        nEnt = 3; setEnt(0, 2, 0, 16); setEnt(1, 0, 3, 5); setEnt(2, 1, 6, 2);
        applyStimulus(16, 1'b0);

        $display("[TB] reset during long press");
        @(negedge clk);
        base = cyc;
        bus.key_in = 3'b101;
        pushExp(1, base + 2, EV_PRESS);
        pushExp(1, base + TL + 2, EV_LONG);
        repeat (14) @(negedge clk);
        checkOutput("held_in_long_ch1", 32'(bus.held), 32'd2);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        bus.key_in = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("[TB] key held through reset release ch2");
        rst_n = 1'b0;
        bus.key_in = 3'b011;
        repeat (3) @(negedge clk);
        nEnt = 1; setEnt(0, 2, 0, 4);
        applyStimulus(4, 1'b1);

        for (int ch = 0; ch < W; ch++)
            checkOutput($sformatf("leftover_ch%0d", ch), 32'(qSize(ch)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
